// File: rtl/regfile_2w2r.sv
// Two-write, two-read register file with write-to-read bypass,
// optional hardwired zero entry and a one-entry-per-cycle clear sweep.
module regfile_2w2r #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din0,
  input  logic [AW-1:0]    waddr0,
  input  logic             we0,
  input  logic [WIDTH-1:0] din1,
  input  logic [AW-1:0]    waddr1,
  input  logic             we1,
  input  logic [AW-1:0]    raddra,
  input  logic [AW-1:0]    raddrb,
  output logic [WIDTH-1:0] douta,
  output logic [WIDTH-1:0] doutb,
  input  logic             clr,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEP  = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_nx;

  function automatic logic in_range(
    input logic [AW-1:0] a
  );
    return {1'b0, a} < DEP;
  endfunction

  // Entry 0 is not a real storage location when hardwired to zero
  function automatic logic live(
    input logic [AW-1:0] a
  );
    return in_range(a) &&
           !(ZERO_REG != 0 && a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] rd(
    input logic [AW-1:0] a
  );
    logic [WIDTH-1:0] v;
    v = '0;
    if (live(a)) begin
      v = mem[a];
      if (BYPASS != 0 && !busy) begin
        if (we1 && waddr1 == a)
          v = din1;
        else if (we0 && waddr0 == a)
          v = din0;
      end
    end
    return v;
  endfunction

  assign busy  = (state == CLEAR);
  assign douta = rd(raddra);
  assign doutb = rd(raddrb);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          ptr_nx   = '0;
        end
      end
      CLEAR: begin
        ptr_nx = ptr + 1'b1;
        if (ptr == LAST) begin
          state_nx = IDLE;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Port 1 is written last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (busy) begin
      mem[ptr] <= '0;
    end else begin
      if (we0 && live(waddr0))
        mem[waddr0] <= din0;
      if (we1 && live(waddr1))
        mem[waddr1] <= din1;
    end
  end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: directed cases plus random traffic
// against an array model, for BYPASS=1 with and without ZERO_REG.
module tb_regfile_2w2r;

  localparam int W = 16;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din0, din1;
  logic [3:0]   waddr0, waddr1;
  logic         we0, we1;
  logic [3:0]   raddra, raddrb;
  logic         clr;
  logic [W-1:0] douta, doutb, za, zb;
  logic         busy, zbusy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  regfile_2w2r #(
    .WIDTH(W), .DEPTH(D), .BYPASS(1), .ZERO_REG(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .din0(din0), .waddr0(waddr0), .we0(we0),
    .din1(din1), .waddr1(waddr1), .we1(we1),
    .raddra(raddra), .raddrb(raddrb),
    .douta(douta), .doutb(doutb),
    .clr(clr), .busy(busy)
  );

  regfile_2w2r #(
    .WIDTH(W), .DEPTH(D), .BYPASS(1), .ZERO_REG(1)
  ) u_zero (
    .clk(clk), .rst(rst),
    .din0(din0), .waddr0(waddr0), .we0(we0),
    .din1(din1), .waddr1(waddr1), .we1(we1),
    .raddra(raddra), .raddrb(raddrb),
    .douta(za), .doutb(zb),
    .clr(clr), .busy(zbusy)
  );

  // Model: plain arrays plus a count of sweep cycles still owed
  logic [W-1:0] m  [D];
  logic [W-1:0] mz [D];
  int           sweep_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        m[i]  = '0;
        mz[i] = '0;
      end
      sweep_left = 0;
    end else if (sweep_left > 0) begin
      m[D - sweep_left]  = '0;
      mz[D - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (we0) begin
        m[waddr0] = din0;
        if (waddr0 != 0) mz[waddr0] = din0;
      end
      if (we1) begin
        m[waddr1] = din1;
        if (waddr1 != 0) mz[waddr1] = din1;
      end
      if (clr) sweep_left = D;
    end
  end

  function automatic logic [W-1:0] expect_rd(
    input bit zero, input logic [3:0] a
  );
    logic [W-1:0] v;
    if (zero && a == 0) return '0;
    v = zero ? mz[a] : m[a];
    if (sweep_left == 0) begin
      if (we1 && waddr1 == a) v = din1;
      else if (we0 && waddr0 == a) v = din0;
    end
    return v;
  endfunction

  task automatic check(
    input string name, input logic [W-1:0] act, input logic [W-1:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model douta", douta, expect_rd(0, raddra));
      check("model doutb", doutb, expect_rd(0, raddrb));
      check("model za", za, expect_rd(1, raddra));
      check("model zb", zb, expect_rd(1, raddrb));
      check("model busy", {15'd0, busy}, {15'd0, sweep_left > 0});
      check("model zbusy", {15'd0, zbusy}, {15'd0, sweep_left > 0});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0 = 0; we1 = 0; clr = 0;
    din0 = '0; din1 = '0;
    waddr0 = '0; waddr1 = '0;
  endtask

  task automatic all_zero(input string name);
    for (int a = 0; a < D; a++) begin
      raddra = 4'(a);
      raddrb = 4'(D - 1 - a);
      @(negedge clk);
      check(name, douta, 16'h0);
      check(name, doutb, 16'h0);
      check(name, za, 16'h0);
      step();
    end
  endtask

  int n;

  initial begin
    rst = 1; idle_in();
    raddra = '0; raddrb = '0;
    step();
    rst = 0;
    chk_en = 1;

    // Reset contents
    all_zero("reset read");
    @(negedge clk);
    check("reset busy", {15'd0, busy}, 16'h0);
    step();

    // Simple writes then reads
    we0 = 1; waddr0 = 3; din0 = 16'h000A; step();
    waddr0 = 4; din0 = 16'h000B; step();
    we0 = 0; raddra = 3; raddrb = 4;
    @(negedge clk);
    check("rd a3", douta, 16'h000A);
    check("rd b4", doutb, 16'h000B);
    step();

    // Collision: port 1 wins, bypassed in the same cycle
    we0 = 1; we1 = 1; waddr0 = 5; waddr1 = 5;
    din0 = 16'h1111; din1 = 16'h2222; raddra = 5;
    @(negedge clk);
    check("bypass collide", douta, 16'h2222);
    step();
    idle_in();
    @(negedge clk);
    check("stored collide", douta, 16'h2222);
    step();

    // Hardwired zero entry
    we0 = 1; waddr0 = 0; din0 = 16'hFFFF; raddra = 0;
    @(negedge clk);
    check("zero bypass", za, 16'h0);
    check("nozero bypass", douta, 16'hFFFF);
    step();
    idle_in();
    @(negedge clk);
    check("zero stored", za, 16'h0);
    check("nozero stored", douta, 16'hFFFF);
    step();

    // Fill, clear sweep length, dropped write while busy
    for (int a = 0; a < D; a += 2) begin
      we0 = 1; waddr0 = 4'(a); din0 = W'($urandom) | 16'h1;
      we1 = 1; waddr1 = 4'(a + 1); din1 = W'($urandom) | 16'h1;
      step();
    end
    idle_in();
    clr = 1; step(); clr = 0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 3) begin
        we0 = 1; waddr0 = 2; din0 = 16'hABCD; raddra = 2;
        @(negedge clk);
        check("no bypass busy", douta == 16'hABCD ? 16'h1 : 16'h0, 16'h0);
      end
      step();
      we0 = 0;
    end
    check("busy cycles", 16'(n), 16'd16);
    all_zero("after clear");

    // Reset in the middle of a sweep
    we0 = 1; waddr0 = 7; din0 = 16'h5555; step();
    idle_in();
    clr = 1; step(); clr = 0;
    repeat (6) step();
    rst = 1; step(); rst = 0;
    check("rst abort busy", {15'd0, busy}, 16'h0);
    all_zero("after rst abort");
    we0 = 1; waddr0 = 9; din0 = 16'h1234; step();
    idle_in(); raddra = 9;
    @(negedge clk);
    check("readback 9", douta, 16'h1234);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      waddr0 = 4'($urandom); waddr1 = 4'($urandom);
      din0 = W'($urandom); din1 = W'($urandom);
      raddra = ($urandom_range(3) == 0) ? waddr1 : 4'($urandom);
      raddrb = ($urandom_range(3) == 0) ? waddr0 : 4'($urandom);
      clr = ($urandom_range(60) == 0);
      rst = ($urandom_range(300) == 0);
      step();
    end
    rst = 0; idle_in();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
